// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment display controller: FSM states,
// active-low segment codes (a..g, MSB = a) and the display-range helper.
package sseg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        if (d < 4'd10) begin
            return SEG_DIGIT[d];
        end
        return SEG_BLANK;
    endfunction

    // Largest value that fits in n decimal digits, evaluated at elaboration.
    function automatic logic [31:0] max_disp(input int unsigned n);
        logic [31:0] p;
        p = 32'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 32'd10;
        end
        return p - 32'd1;
    endfunction

endpackage

// File: rtl/sseg_display_ctrl_bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per clock,
// exactly IN_W steps after start_i. BCD bits beyond 4*N_DIGITS are dropped.
module bin2bcd_seq
    import sseg_pkg::*;
#(
    parameter int IN_W     = 14,
    parameter int N_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [IN_W-1:0]         bin_i,
    output logic                    done_o,
    output logic [4*N_DIGITS-1:0]   bcd_o
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);

    logic [IN_W-1:0]  bin_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] adj;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             last;

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_adj
            assign adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                               : bcd_q[4*gi +: 4];
        end
    endgenerate

    assign last   = (cnt_q == CNT_W'(IN_W - 1));
    // High during the final step; bcd_o holds the full result from the next cycle on.
    assign done_o = busy_q && last;
    assign bcd_o  = bcd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            bin_q  <= bin_i;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            {bcd_q, bin_q} <= {adj, bin_q} << 1;
            cnt_q          <= cnt_q + CNT_W'(1);
            busy_q         <= !last;
        end
    end

endmodule

// File: rtl/sseg_display_ctrl.sv
// Multiplexed seven-segment controller: accepts a binary value, converts it to
// BCD, then scans the digits. Leading-zero blanking is enabled by SSEG_LZB_EN.
module sseg_display_ctrl
    import sseg_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int IN_W     = 14,
    parameter int CLK_DIV  = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_W-1:0]     bin,
    output logic [0:6]          SSeg,
    output logic [N_DIGITS-1:0] an,
    output logic                ovf
);

    localparam int          BCD_W   = 4 * N_DIGITS;
    localparam int          DIV_W   = $clog2(CLK_DIV);
    localparam int          IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [31:0] MAX_VAL = max_disp(N_DIGITS);

    state_e               state_q;
    logic                 in_ready_q;
    logic                 ovf_pend_q;
    logic                 ovf_q, ovf_d;
    logic [BCD_W-1:0]     disp_q, disp_d;
    logic                 accept, ovf_in, conv_done;
    logic [BCD_W-1:0]     conv_bcd;

    logic [DIV_W-1:0]     div_q, div_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 wrap;
    logic [N_DIGITS-1:0]  an_q, an_d;
    logic [0:6]           sseg_q;
    logic [6:0]           seg_d;
    logic [3:0]           dig [N_DIGITS];
    logic [N_DIGITS-1:0]  blank;

    assign accept = in_valid && in_ready_q;
    assign ovf_in = {{(32-IN_W){1'b0}}, bin} > MAX_VAL;

    bin2bcd_seq #(
        .IN_W     (IN_W),
        .N_DIGITS (N_DIGITS)
    ) u_conv (
        .clk     (clk),
        .rst_n   (rst),
        .start_i (accept),
        .bin_i   (bin),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b1;
            ovf_pend_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q    <= ST_CONV;
                        in_ready_q <= 1'b0;
                        ovf_pend_q <= ovf_in;
                    end
                end
                ST_CONV: begin
                    if (conv_done) begin
                        state_q <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Display value and overflow flag change together, only in COMMIT.
    assign disp_d = (state_q == ST_COMMIT) ? conv_bcd   : disp_q;
    assign ovf_d  = (state_q == ST_COMMIT) ? ovf_pend_q : ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            disp_q <= disp_d;
            ovf_q  <= ovf_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_dig
            assign dig[gi] = disp_d[4*gi +: 4];
        end
    endgenerate

`ifdef SSEG_LZB_EN
    // lz[i] is set when digit i and every more significant digit are zero.
    logic [N_DIGITS:1] lz;
    assign lz[N_DIGITS] = 1'b1;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_lzb
            if (gi == 0) begin : g_d0
                assign blank[gi] = 1'b0;
            end else begin : g_dn
                if (gi < N_DIGITS) begin : g_chain
                    assign lz[gi] = lz[gi+1] && (dig[gi] == 4'd0);
                end
                assign blank[gi] = lz[gi];
            end
        end
    endgenerate
`else
    assign blank = '0;
`endif

    always_comb begin
        wrap  = (div_q == DIV_W'(CLK_DIV - 1));
        div_d = wrap ? '0 : div_q + DIV_W'(1);
        idx_d = idx_q;
        if (wrap) begin
            idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_comb begin
        if (ovf_d) begin
            seg_d = SEG_DASH;
        end else if (blank[idx_d]) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_code(dig[idx_d]);
        end
        an_d = ~(N_DIGITS'(1) << idx_d);
    end

    // Outputs are registered from next-state values so they track idx_q exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= '0;
            idx_q  <= '0;
            an_q   <= '1;
            sseg_q <= SEG_BLANK;
        end else begin
            div_q  <= div_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            sseg_q <= seg_d;
        end
    end

    assign in_ready = in_ready_q;
    assign ovf      = ovf_q;
    assign an       = an_q;
    assign SSeg     = sseg_q;

endmodule
